mux8_rr_arbiter: RTL and testbench
==================================

# mux8_rr_arbiter

Round-robin arbiter and sequencer for the 8-way, 16-bit mux datapath (Mux8Way16). It shares one 16-bit output channel between eight requesters. It registers the winning select code, drives the one-hot grant, and presents the selected word with a valid/ready handshake. It sits between requester blocks and any single-consumer sink (register file write port, output latch).

## Interface
- MAX_BURST, default 1: number of consecutive transfers a granted requester may make before the pointer rotates; legal range 1..15.
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  8  request per requester; bit k belongs to in{k}.
- in0..in7  in  16 each  requester data words.
- grant  out  8  one-hot grant, registered; all zero when idle.
- sel  out  3  registered select code, equal to the index of the grant bit.
- out_data  out  16  combinational Mux8Way16(in0..in7, sel).
- out_valid  out  1  registered; high while a grant is held.
- out_ready  in  1  sink accepts out_data this cycle.
- busy  out  1  equal to out_valid; provided for status.

## Operation
- FSM states:
  - IDLE (2'd0): no grant held.
  - GRANT (2'd1): one grant held.
- Internal state:
  - ptr, 3 bits: search start index.
  - bcnt, 4 bits: transfers completed in the current burst.
- Pick function: first k with req[k]=1, searching ptr, ptr+1, … ptr+7 mod 8.
- IDLE → GRANT:
  - Taken when req != 0.
  - Registers sel = pick, sets grant[pick]=1, out_valid=1, bcnt=0.
- A transfer occurs on any GRANT cycle with out_valid & out_ready.
- On a transfer:
  - bcnt+1 < MAX_BURST and req[sel]=1: stay in GRANT with the same sel; bcnt++.
  - Otherwise: ptr = sel+1 mod 8 (wrap 7→0), bcnt=0.
    - Re-pick from the new ptr in the same cycle.
    - If the pick is non-empty, load the new sel and grant and stay in GRANT (zero-bubble handoff).
    - If empty, go to IDLE with grant=0 and out_valid=0.
  - The previous winner is re-eligible, but last in search order.
- Withdrawal: req[sel]=0 in GRANT without a transfer.
  - Next cycle is IDLE and grant is cleared.
  - ptr and bcnt are unchanged.
  - Requesters must hold req until their transfer.
- out_ready while out_valid=0 is ignored.
- req changes on non-granted bits have no effect until the next pick.
- Reset values: state=IDLE, ptr=0, bcnt=0, sel=0, grant=8'h00, out_valid=0, busy=0.
  - out_data therefore shows in0 after reset.
- Reset mid-transfer: reset dominates out_ready and req.
  - The pending word is not counted as transferred.
  - All state returns to reset values on that edge.
- Illegal state encodings return to IDLE on the next edge.

## Timing
- Grant latency: req sampled at edge N → grant, sel, and out_valid visible after edge N (one cycle).
- out_data is valid in the same cycle as out_valid; it is combinational from the registered sel and the live in{k}.
  - Requesters must hold data stable while granted.
- Transfer at edge M → the next grant is visible after edge M.
  - Sustained throughput: 1 word/cycle with out_ready held high.
- Stall: out_ready=0 holds sel, grant, and out_valid indefinitely.
- Fairness: with all req high and MAX_BURST=1, each index is granted exactly once per 8 transfers.

## Structure
- Shared include mux_arb_defs.v contains:
  - State localparams ST_IDLE and ST_GRANT.
  - SEL_W=3 and N_REQ=8.
- Sub-module rr_pick8: combinational rotating priority encoder.
  - Inputs: req[7:0], ptr[2:0].
  - Outputs: any, idx[2:0].
  - Instantiated once and shared by the IDLE and handoff paths.
- Datapath: one existing Mux8Way16 instance driven by sel; no new mux logic.

## Test plan
- Reset: assert reset for 2 cycles with req=8'hFF.
  - Expect grant=00, out_valid=0, sel=0, out_data=in0.
  - First grant appears one cycle after reset deasserts, with sel=0.
- Single requester: in_k=16'hk, req=8'h20, out_ready=1.
  - Grant=20 and out_data=0005 after one cycle.
  - Transfers every cycle; ptr rotates, but 5 is re-picked each time.
- Full rotation: req=FF, out_ready=1, MAX_BURST=1.
  - sel sequence is 0,1,…,7,0 with no bubbles.
  - out_data is 0000…0007.
- Stall and wrap: req=8'h81 with ptr at 7; hold out_ready=0 for 5 cycles.
  - sel=7 and out_data=0007 are held.
  - After out_ready=1, next sel=0 (wrap).
- Burst and withdrawal:
  - MAX_BURST=3, req=8'h0C: sel=2 for 3 transfers, then sel=3.
  - Drop req[3] before transfer: IDLE next cycle, then re-grant to 2.
- Mid-operation reset: reset while granted with out_ready=1.
  - No extra grant and all outputs return to reset values.
  - The next pick starts from ptr=0.

Source files
------------

// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared constants and helpers for the 8-way round-robin arbiter slice.
// Imported by the interface, the priority encoder and the top.
package mux8_rr_arbiter_pkg;

    localparam int N_REQ  = 8;
    localparam int SEL_W  = 3;
    localparam int DATA_W = 16;
    localparam int BCNT_W = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;

    function automatic logic [N_REQ-1:0] onehot8(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] g;
        g      = '0;
        g[idx] = 1'b1;
        return g;
    endfunction

endpackage

// File: rtl/mux8_rr_arbiter_if.sv
// Requester/sink bundle for mux8_rr_arbiter: requests, data words,
// grant/select status and the valid/ready output handshake.
interface mux8_rr_arbiter_if;
    import mux8_rr_arbiter_pkg::*;

    logic [N_REQ-1:0]  req;
    logic [DATA_W-1:0] in0;
    logic [DATA_W-1:0] in1;
    logic [DATA_W-1:0] in2;
    logic [DATA_W-1:0] in3;
    logic [DATA_W-1:0] in4;
    logic [DATA_W-1:0] in5;
    logic [DATA_W-1:0] in6;
    logic [DATA_W-1:0] in7;
    logic [N_REQ-1:0]  grant;
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              busy;

    modport master (
        output req, in0, in1, in2, in3, in4, in5, in6, in7, out_ready,
        input  grant, sel, out_data, out_valid, busy
    );

    modport slave (
        input  req, in0, in1, in2, in3, in4, in5, in6, in7, out_ready,
        output grant, sel, out_data, out_valid, busy
    );

endinterface

// File: rtl/mux8_rr_arbiter_rr_pick8.sv
// Rotating priority encoder: first set request bit at or after ptr, wrapping mod 8.
// Also holds the legacy Mux8Way16 datapath mux used by the arbiter top.
module rr_pick8
    import mux8_rr_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] k;

    // Scan from the farthest offset down so the nearest hit is written last.
    always_comb begin
        any = 1'b0;
        idx = '0;
        k   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            k = ptr + SEL_W'(i);
            if (req[k]) begin
                any = 1'b1;
                idx = k;
            end
        end
    end

endmodule

module Mux8Way16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [15:0] c,
    input  logic [15:0] d,
    input  logic [15:0] e,
    input  logic [15:0] f,
    input  logic [15:0] g,
    input  logic [15:0] h,
    input  logic [2:0]  sel,
    output logic [15:0] out
);

    always_comb begin
        case (sel)
            3'd0:    out = a;
            3'd1:    out = b;
            3'd2:    out = c;
            3'd3:    out = d;
            3'd4:    out = e;
            3'd5:    out = f;
            3'd6:    out = g;
            default: out = h;
        endcase
    end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sharing one 16-bit channel among eight requesters,
// with optional multi-word bursts and zero-bubble handoff between winners.
module mux8_rr_arbiter
    import mux8_rr_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 1
) (
    input  logic              clock,
    input  logic              reset,
    mux8_rr_arbiter_if.slave  bus
);

    logic [1:0]        state_q, state_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic              valid_q, valid_d;

    logic [SEL_W-1:0]  pick_ptr;
    logic              pick_any;
    logic [SEL_W-1:0]  pick_idx;
    logic              xfer;
    logic              burst_more;

    // In GRANT the only pick that matters is the handoff one, which starts after the current winner.
    assign pick_ptr   = (state_q == ST_GRANT) ? sel_q + SEL_W'(1) : ptr_q;
    assign xfer       = valid_q && bus.out_ready;
    assign burst_more = ((int'(bcnt_q) + 1) < MAX_BURST) && bus.req[sel_q];

    rr_pick8 u_pick (
        .req (bus.req),
        .ptr (pick_ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        bcnt_d  = bcnt_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        valid_d = valid_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d = ST_GRANT;
                    sel_d   = pick_idx;
                    grant_d = onehot8(pick_idx);
                    valid_d = 1'b1;
                    bcnt_d  = '0;
                end
            end
            ST_GRANT: begin
                if (xfer) begin
                    if (burst_more) begin
                        bcnt_d = bcnt_q + BCNT_W'(1);
                    end else begin
                        ptr_d  = sel_q + SEL_W'(1);
                        bcnt_d = '0;
                        if (pick_any) begin
                            sel_d   = pick_idx;
                            grant_d = onehot8(pick_idx);
                        end else begin
                            state_d = ST_IDLE;
                            grant_d = '0;
                            valid_d = 1'b0;
                        end
                    end
                end else if (!bus.req[sel_q]) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            bcnt_q  <= '0;
            sel_q   <= '0;
            grant_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            bcnt_q  <= bcnt_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.sel       = sel_q;
    assign bus.out_valid = valid_q;
    assign bus.busy      = valid_q;

    Mux8Way16 u_mux (
        .a   (bus.in0),
        .b   (bus.in1),
        .c   (bus.in2),
        .d   (bus.in3),
        .e   (bus.in4),
        .f   (bus.in5),
        .g   (bus.in6),
        .h   (bus.in7),
        .sel (sel_q),
        .out (bus.out_data)
    );

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Scoreboard bench for mux8_rr_arbiter: one instance with MAX_BURST=1 and one with MAX_BURST=3,
// each word k carrying the value k so the expected data follows from the expected select.
module tb_mux8_rr_arbiter;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    mux8_rr_arbiter_if bus1 ();
    mux8_rr_arbiter_if bus3 ();

    mux8_rr_arbiter #(.MAX_BURST(1)) u_dut1 (.clock(clock), .reset(reset), .bus(bus1));
    mux8_rr_arbiter #(.MAX_BURST(3)) u_dut3 (.clock(clock), .reset(reset), .bus(bus3));

    logic [2:0] exp_q1[$];
    logic [2:0] exp_q3[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Packed layout: {3'b0, grant, sel, out_data, out_valid, busy}
    function automatic logic [31:0] pk(input logic [7:0] g, input logic [2:0] s,
                                       input logic [15:0] d, input logic v, input logic b);
        return {3'b000, g, s, d, v, b};
    endfunction

    function automatic logic [31:0] exp_grant(input logic [2:0] s);
        return pk(8'd1 << s, s, {13'd0, s}, 1'b1, 1'b1);
    endfunction

    function automatic logic [31:0] snap1();
        return pk(bus1.grant, bus1.sel, bus1.out_data, bus1.out_valid, bus1.busy);
    endfunction

    function automatic logic [31:0] snap3();
        return pk(bus3.grant, bus3.sel, bus3.out_data, bus3.out_valid, bus3.busy);
    endfunction

    function automatic logic [31:0] idle1();
        return {22'd0, bus1.grant, bus1.out_valid, bus1.busy};
    endfunction

    function automatic logic [31:0] idle3();
        return {22'd0, bus3.grant, bus3.out_valid, bus3.busy};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        if (!reset && bus1.out_valid && bus1.out_ready) begin
            if (exp_q1.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dut1_xfer: got unexpected transfer sel=%0d expected none", bus1.sel);
            end else begin
                logic [2:0] e;
                e = exp_q1.pop_front();
                check("dut1_xfer", snap1(), exp_grant(e));
            end
        end
    end

    always @(negedge clock) begin
        if (!reset && bus3.out_valid && bus3.out_ready) begin
            if (exp_q3.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dut3_xfer: got unexpected transfer sel=%0d expected none", bus3.sel);
            end else begin
                logic [2:0] e;
                e = exp_q3.pop_front();
                check("dut3_xfer", snap3(), exp_grant(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of stimulus");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        bus1.in0 = 16'h0000; bus1.in1 = 16'h0001; bus1.in2 = 16'h0002; bus1.in3 = 16'h0003;
        bus1.in4 = 16'h0004; bus1.in5 = 16'h0005; bus1.in6 = 16'h0006; bus1.in7 = 16'h0007;
        bus3.in0 = 16'h0000; bus3.in1 = 16'h0001; bus3.in2 = 16'h0002; bus3.in3 = 16'h0003;
        bus3.in4 = 16'h0004; bus3.in5 = 16'h0005; bus3.in6 = 16'h0006; bus3.in7 = 16'h0007;
        bus1.req = 8'hFF; bus1.out_ready = 1'b0;
        bus3.req = 8'h00; bus3.out_ready = 1'b0;

        // Reset held two cycles with all requests up
        cyc(2);
        check("reset_state", snap1(), pk(8'h00, 3'd0, 16'h0000, 1'b0, 1'b0));
        check("dut3_reset_state", snap3(), pk(8'h00, 3'd0, 16'h0000, 1'b0, 1'b0));
        reset = 1'b0;
        cyc(1);
        check("first_grant", snap1(), exp_grant(3'd0));

        // Full rotation with MAX_BURST=1
        bus1.out_ready = 1'b1;
        for (int i = 0; i < 9; i++) exp_q1.push_back(3'(i));
        cyc(9);
        check("rotation_handoff", snap1(), exp_grant(3'd1));
        check("rotation_drained", 32'(exp_q1.size()), 32'd0);
        bus1.req = 8'h00; bus1.out_ready = 1'b0;
        cyc(1);
        check("withdraw_idle", idle1(), 32'd0);

        // out_ready while idle is ignored
        bus1.out_ready = 1'b1;
        cyc(2);
        check("ready_while_idle", idle1(), 32'd0);
        bus1.out_ready = 1'b0;

        // Single requester 5 (ptr is 1)
        bus1.req = 8'h20; bus1.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) exp_q1.push_back(3'd5);
        cyc(5);
        check("single_regrant", snap1(), exp_grant(3'd5));
        bus1.req = 8'h00; bus1.out_ready = 1'b0;
        cyc(1);
        check("single_idle", idle1(), 32'd0);

        // Move ptr to 7, then stall on 7 and wrap to 0 (ptr is 6)
        bus1.req = 8'hC0; bus1.out_ready = 1'b1;
        exp_q1.push_back(3'd6);
        cyc(2);
        bus1.req = 8'h81; bus1.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall_hold", snap1(), exp_grant(3'd7));
            cyc(1);
        end
        check("stall_end", snap1(), exp_grant(3'd7));
        bus1.out_ready = 1'b1;
        exp_q1.push_back(3'd7);
        exp_q1.push_back(3'd0);
        cyc(2);
        check("wrap_next", snap1(), exp_grant(3'd7));
        bus1.req = 8'h00; bus1.out_ready = 1'b0;
        cyc(1);
        check("wrap_idle", idle1(), 32'd0);

        // Mid-operation reset (ptr is 1)
        bus1.req = 8'hFF; bus1.out_ready = 1'b1;
        exp_q1.push_back(3'd1);
        cyc(2);
        check("pre_reset_grant", snap1(), exp_grant(3'd2));
        reset = 1'b1;
        cyc(1);
        check("mid_reset_state", snap1(), pk(8'h00, 3'd0, 16'h0000, 1'b0, 1'b0));
        reset = 1'b0; bus1.out_ready = 1'b0;
        cyc(1);
        check("post_reset_pick", snap1(), exp_grant(3'd0));
        bus1.req = 8'h00;
        cyc(1);
        check("post_reset_idle", idle1(), 32'd0);
        check("dut1_drained", 32'(exp_q1.size()), 32'd0);

        // Burst of 3 on requester 2, then handoff to 3 (MAX_BURST=3, ptr is 0)
        bus3.req = 8'h0C; bus3.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) exp_q3.push_back(3'd2);
        cyc(4);
        check("burst_rotate", snap3(), exp_grant(3'd3));
        bus3.req = 8'h04; bus3.out_ready = 1'b0;
        cyc(1);
        check("burst_withdraw_idle", idle3(), 32'd0);
        cyc(1);
        check("burst_regrant", snap3(), exp_grant(3'd2));
        bus3.out_ready = 1'b1;
        exp_q3.push_back(3'd2);
        cyc(1);
        check("burst_continue", snap3(), exp_grant(3'd2));
        bus3.req = 8'h00; bus3.out_ready = 1'b0;
        cyc(1);
        check("burst_idle", idle3(), 32'd0);
        check("dut3_drained", 32'(exp_q3.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
